// File: rtl/goto_rep_pkg.sv
// Shared types and default widths for the goto-repetition checker.
package goto_rep_pkg;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_TO_W   = 8;
  localparam int DEF_STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXPECT = 2'd2
  } state_t;

  typedef enum logic {
    CAUSE_NO_DONE = 1'b0,
    CAUSE_TIMEOUT = 1'b1
  } fail_cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count increments while below all-ones, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/goto_rep_checker.sv
// Run-time monitor for "trig rises |-> evt[->N] ##1 done" with optional
// timeout. One attempt in flight; rises seen while busy are dropped.
module goto_rep_checker
  import goto_rep_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TO_W   = DEF_TO_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic              trig,
  input  logic              evt,
  input  logic              done,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              fail_cause,
  output logic [STAT_W-1:0] pass_cnt,
  output logic [STAT_W-1:0] fail_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  state_t           r_state;
  logic             r_trig_q;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_hits;
  logic [TO_W-1:0]  r_to;
  logic [TO_W-1:0]  r_wait;
  logic             r_pass;
  logic             r_fail;
  logic             r_cause;

  logic             w_rise;
  logic             w_start;
  logic             w_drop;
  logic [CNT_W-1:0] w_n_lat;
  logic [CNT_W-1:0] w_hits_nxt;
  logic [TO_W-1:0]  w_wait_nxt;
  state_t           w_state_nxt;
  logic             w_pass_nxt;
  logic             w_fail_nxt;
  logic             w_cause_nxt;

  assign w_rise     = trig & ~r_trig_q;
  assign w_start    = (r_state == IDLE) & enable & w_rise;
  assign w_drop     = (r_state != IDLE) & w_rise;
  // N of zero is treated as one so an attempt always needs at least one hit.
  assign w_n_lat    = (cfg_count == '0) ? CNT_W'(1) : cfg_count;
  assign w_hits_nxt = r_hits + {{(CNT_W-1){1'b0}}, evt};
  assign w_wait_nxt = r_wait + TO_W'(1);

  // Next-state and verdict decode; a completing hit beats a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    w_cause_nxt = CAUSE_NO_DONE;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = (evt && (w_n_lat == CNT_W'(1))) ? EXPECT : COUNT;
        end
      end
      COUNT: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_hits_nxt == r_n) begin
          w_state_nxt = EXPECT;
        end else if ((r_to != '0) && (w_wait_nxt == r_to)) begin
          w_state_nxt = IDLE;
          w_fail_nxt  = 1'b1;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      EXPECT: begin
        w_state_nxt = IDLE;
        if (enable) begin
          w_pass_nxt = done;
          w_fail_nxt = ~done;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, rise-detect history and registered verdict pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_trig_q <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_cause  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_q <= trig;
      r_pass   <= w_pass_nxt;
      r_fail   <= w_fail_nxt;
      r_cause  <= w_cause_nxt;
    end
  end

  // Per-attempt config latch plus hit and wait counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= '0;
      r_to   <= '0;
      r_hits <= '0;
      r_wait <= '0;
    end else if (w_start) begin
      r_n    <= w_n_lat;
      r_to   <= cfg_timeout;
      r_hits <= {{(CNT_W-1){1'b0}}, evt};
      r_wait <= '0;
    end else if (r_state == COUNT) begin
      r_hits <= w_hits_nxt;
      r_wait <= w_wait_nxt;
    end
  end

  sat_counter #(.W(STAT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pass_nxt),
    .count (pass_cnt)
  );

  sat_counter #(.W(STAT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_fail_nxt),
    .count (fail_cnt)
  );

  sat_counter #(.W(STAT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_drop),
    .count (drop_cnt)
  );

  assign busy       = (r_state != IDLE);
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_cause = r_cause;

endmodule
